// File: rtl/melody_sequencer.sv
// melody_sequencer: plays timed notes from a 1-cycle-latency ROM into a tone generator
//   clk, rst                 clock, synchronous active-high reset
//   start, stop, loop        begin playback (IDLE only), abort, repeat song at its end
//   rom_addr, rom_data       ROM address out, {dur[15:10], freq[9:0]} in
//   note_code, sound_en      tone code and buzzer gate
//   busy, done               not-IDLE flag, one-cycle completion pulse
module melody_sequencer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int UNIT_MS = 125,
  parameter int GAP_MS  = 20,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [9:0]        note_code,
  output logic              sound_en,
  output logic              busy,
  output logic              done
);
  localparam int TICK = CLK_HZ / 1000;
  localparam int PW = TICK > 1 ? $clog2(TICK) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0] ms_q, ms_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0] note_q, note_d;
  logic snd_q, snd_d;
  logic [5:0] dur;
  logic tick, last, wrap, load;
  assign dur  = rom_data[15:10];
  assign tick = pre_q == PW'(TICK - 1);
  assign last = tick && ms_q == 16'd1;
  assign wrap = addr_q == '1;
  assign load = state_q == LATCH && state_d == PLAY;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      ms_q    <= '0;
      addr_q  <= '0;
      note_q  <= '0;
      snd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      snd_q   <= snd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (stop) state_d = IDLE;
    else
      case (state_q)
        IDLE:    state_d = start ? FETCH : IDLE;
        FETCH:   state_d = LATCH;
        LATCH:   state_d = dur == '0 ? (loop ? FETCH : DONE) : PLAY;
        PLAY:    state_d = last ? GAP : PLAY;
        GAP:     state_d = !last ? GAP : wrap && !loop ? DONE : FETCH;
        default: state_d = IDLE;
      endcase
  end
  // prescaler restarts on entry to PLAY/GAP so every ms phase is exactly TICK cycles
  always_comb begin
    pre_d  = (state_d != state_q && (state_d == PLAY || state_d == GAP)) || tick ? '0 : pre_q + 1'b1;
    ms_d   = load ? 16'(32'(dur) * UNIT_MS - GAP_MS) :
             state_q == PLAY && state_d == GAP ? 16'(GAP_MS) :
             (state_q == PLAY || state_q == GAP) && tick ? ms_q - 16'd1 : ms_q;
    addr_d = state_d == FETCH ? (state_q == GAP && !wrap ? addr_q + 1'b1 : '0) : addr_q;
    note_d = load ? rom_data[9:0] : note_q;
    snd_d  = load ? |rom_data[9:0] : state_d == PLAY && snd_q;
  end
  always_comb begin
    busy      = state_q != IDLE;
    done      = state_q == DONE;
    rom_addr  = addr_q;
    note_code = note_q;
    sound_en  = snd_q;
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed checks of note timing, rests, looping, stop, wrap and reset
module tb_melody_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [1:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [9:0] note_code;
  logic sound_en, busy, done;
  logic [15:0] rom [4];
  int total = 0, passed = 0, ndone = 0, n, d0;
  always #5 clk = ~clk;
  melody_sequencer #(.CLK_HZ(4000), .UNIT_MS(10), .GAP_MS(2), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_code(note_code),
    .sound_en(sound_en), .busy(busy), .done(done)
  );
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(negedge clk) if (done) ndone <= ndone + 1;
  function automatic logic [15:0] ent(int d, int f);
    return {6'(d), 10'(f)};
  endfunction
  function automatic logic sig(int s);
    return s == 0 ? sound_en : done;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else passed++;
  endtask
  task automatic run_len(input int s, input logic v, output int cnt);
    cnt = 0;
    while (sig(s) === v && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic go();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  initial begin
    rom = '{default: 16'h0};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_note", 32'(note_code), 0);
    chk("rst_outs", {29'd0, sound_en, busy, done}, 0);
    // single tone
    rom[0] = ent(3, 440); rom[1] = ent(0, 0);
    go();
    run_len(0, 0, n); chk("tone_lead", n, 2);
    run_len(0, 1, n); chk("tone_high", n, 112);
    chk("tone_code", 32'(note_code), 440);
    d0 = ndone;
    run_len(1, 0, n); chk("tone_gap", n, 10);
    run_len(1, 1, n); chk("tone_done_w", n, 1);
    chk("tone_done_n", ndone - d0, 1);
    chk("tone_busy", 32'(busy), 0);
    chk("tone_hold", 32'(note_code), 440);
    // rest then note
    do_reset();
    rom[0] = ent(1, 0); rom[1] = ent(2, 262); rom[2] = ent(0, 0);
    go();
    run_len(0, 0, n); chk("rest_low", n, 44);
    chk("rest_code", 32'(note_code), 262);
    run_len(0, 1, n); chk("rest_high", n, 72);
    run_len(1, 0, n); chk("rest_gap", n, 10);
    // looping
    do_reset();
    rom[0] = ent(1, 523); rom[1] = ent(0, 0);
    loop = 1'b1;
    d0 = ndone;
    go();
    run_len(0, 0, n); chk("loop_lead", n, 2);
    run_len(0, 1, n); chk("loop_high1", n, 32);
    run_len(0, 0, n); chk("loop_low1", n, 12);
    chk("loop_code", 32'(note_code), 523);
    run_len(0, 1, n); chk("loop_high2", n, 32);
    run_len(0, 0, n); chk("loop_low2", n, 12);
    chk("loop_nodone", ndone - d0, 0);
    loop = 1'b0;
    run_len(0, 1, n); chk("loop_high3", n, 32);
    run_len(1, 0, n); chk("loop_end_gap", n, 10);
    run_len(1, 1, n); chk("loop_done_w", n, 1);
    chk("loop_done_n", ndone - d0, 1);
    // stop mid-note
    do_reset();
    rom[0] = ent(3, 440); rom[1] = ent(0, 0);
    d0 = ndone;
    go();
    run_len(0, 0, n);
    repeat (49) @(negedge clk);
    chk("stop_pre", 32'(sound_en), 1);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    chk("stop_outs", {29'd0, sound_en, busy, done}, 0);
    chk("stop_code", 32'(note_code), 440);
    repeat (5) @(negedge clk);
    chk("stop_nodone", ndone - d0, 0);
    // start and stop together in IDLE
    do_reset();
    start = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(busy), 0);
    chk("ss_addr", 32'(rom_addr), 0);
    // start held while busy
    go();
    run_len(0, 0, n);
    start = 1'b1;
    run_len(0, 1, n); chk("sb_high", n, 112);
    start = 1'b0;
    run_len(1, 0, n); chk("sb_gap", n, 10);
    run_len(1, 1, n); chk("sb_done_w", n, 1);
    chk("sb_busy", 32'(busy), 0);
    // full ROM without end marker wraps into done
    do_reset();
    for (int i = 0; i < 4; i++) rom[i] = ent(1, 100 * (i + 1));
    d0 = ndone;
    go();
    for (int i = 0; i < 4; i++) begin
      run_len(0, 0, n); chk($sformatf("wrap_low%0d", i), n, i == 0 ? 2 : 10);
      chk($sformatf("wrap_code%0d", i), 32'(note_code), 100 * (i + 1));
      run_len(0, 1, n); chk($sformatf("wrap_high%0d", i), n, 32);
    end
    run_len(1, 0, n); chk("wrap_gap", n, 8);
    run_len(1, 1, n); chk("wrap_done_w", n, 1);
    chk("wrap_done_n", ndone - d0, 1);
    // reset mid-note
    do_reset();
    rom[0] = ent(3, 440); rom[1] = ent(0, 0);
    go();
    run_len(0, 0, n);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mrst_addr", 32'(rom_addr), 0);
    chk("mrst_note", 32'(note_code), 0);
    chk("mrst_outs", {29'd0, sound_en, busy, done}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
